// File: rtl/div_iter_ctrl_pkg.sv
// div_iter_ctrl_pkg: shared definitions for the iterative divider sequencer.
// Holds the 2-bit FSM state encodings DIV_IDLE, DIV_CALC and DIV_DONE.
// Optional feature macro: DIV_EARLY_OUT_EN. It is left undefined by default;
// define it on the command line to finish divide-by-zero and signed-overflow
// operations straight from IDLE.
package div_iter_ctrl_pkg;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;
endpackage

// File: rtl/div_iter_ctrl_add.sv
// add_without_Cout: carry-in adder with the carry-out dropped.
// The divider shares this one adder between trial subtraction and negation.
// Ports:
//   i_a, i_b  W-bit addends
//   i_cin     carry in
//   o_sum     W-bit sum (carry out discarded)
module add_without_Cout #(
   parameter int W = 33
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum
);
   assign o_sum = i_a + i_b + W'(i_cin);
endmodule

// File: rtl/div_iter_ctrl.sv
// div_iter_ctrl: shift-subtract divider sequencer for DIV/DIVU/REM/REMU.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               abort any in-flight operation and discard its result
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   op_a, op_b          dividend, divisor
//   is_signed, is_rem   signed operation, return remainder instead of quotient
//   out_valid/out_ready result handshake; result is held until taken
//   result              quotient or remainder
//   busy                high whenever the sequencer is not idle
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, divide-by-zero
// and signed overflow are resolved at accept and go straight to DONE.
module div_iter_ctrl
   import div_iter_ctrl_pkg::*;
#(
   parameter int DATA_LEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_LEN-1:0] op_a,
   input  logic [DATA_LEN-1:0] op_b,
   input  logic                is_signed,
   input  logic                is_rem,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] result,
   output logic                busy
);
   localparam int CW = $clog2(DATA_LEN) + 1;
   localparam logic [DATA_LEN-1:0] MIN_NEG = {1'b1, {(DATA_LEN-1){1'b0}}};

   div_state_t          r_state, w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic [DATA_LEN-1:0] r_r, r_q, r_d, r_result;
   logic                r_sa, r_sb, r_rem, r_dz, r_ov;
   logic                w_acc, w_fix, w_sa, w_sb, w_dz, w_ov, w_early, w_neg;
   logic [DATA_LEN-1:0] w_x, w_corr, w_fix_res;
   logic [DATA_LEN:0]   w_add_a, w_add_b, w_sum;

   assign in_ready  = r_state == DIV_IDLE;
   assign out_valid = r_state == DIV_DONE;
   assign busy      = r_state != DIV_IDLE;
   assign result    = r_result;

   assign w_acc = in_valid & in_ready & ~flush;
   assign w_sa  = is_signed & op_a[DATA_LEN-1];
   assign w_sb  = is_signed & op_b[DATA_LEN-1];
   assign w_dz  = op_b == '0;
   assign w_ov  = is_signed & (op_a == MIN_NEG) & (&op_b);

`ifdef DIV_EARLY_OUT_EN
   logic [DATA_LEN-1:0] w_early_res;
   assign w_early     = w_dz | w_ov;
   assign w_early_res = w_dz ? (is_rem ? op_a : '1) : (is_rem ? '0 : op_a);
`else
   assign w_early = 1'b0;
`endif

   // cnt == DATA_LEN marks the extra fix-up cycle at the end of CALC
   assign w_fix = r_cnt == CW'(DATA_LEN);
   assign w_x   = r_rem ? r_r : r_q;

   // Iteration: {R,Q[MSB]} - D.  Fix-up: 0 - x.  Both use carry-in 1.
   assign w_add_a = w_fix ? '0 : {r_r, r_q[DATA_LEN-1]};
   assign w_add_b = w_fix ? ~{1'b0, w_x} : ~{1'b0, r_d};

   add_without_Cout #(.W(DATA_LEN + 1)) u_add (
      .i_a   (w_add_a),
      .i_b   (w_add_b),
      .i_cin (1'b1),
      .o_sum (w_sum)
   );

   // Quotient takes the sign of sa^sb, remainder the sign of the dividend.
   // The divide-by-zero remainder is therefore already op_a after correction.
   assign w_neg     = r_rem ? r_sa : r_sa ^ r_sb;
   assign w_corr    = w_neg ? w_sum[DATA_LEN-1:0] : w_x;
   assign w_fix_res = r_dz ? (r_rem ? w_corr : '1) :
                      r_ov ? (r_rem ? '0 : MIN_NEG) : w_corr;

   always_comb begin
      w_state_nxt = r_state;
      if (flush)
         w_state_nxt = DIV_IDLE;
      else if (r_state == DIV_IDLE && in_valid)
         w_state_nxt = w_early ? DIV_DONE : DIV_CALC;
      else if (r_state == DIV_CALC && w_fix)
         w_state_nxt = DIV_DONE;
      else if (r_state == DIV_DONE && out_ready)
         w_state_nxt = DIV_IDLE;
   end

   always_ff @(posedge clk)
      if (rst)
         r_state <= DIV_IDLE;
      else
         r_state <= w_state_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_r      <= '0;
         r_q      <= '0;
         r_d      <= '0;
         r_result <= '0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_rem    <= 1'b0;
         r_dz     <= 1'b0;
         r_ov     <= 1'b0;
      end else if (w_acc) begin
         r_sa  <= w_sa;
         r_sb  <= w_sb;
         r_q   <= w_sa ? -op_a : op_a;
         r_d   <= w_sb ? -op_b : op_b;
         r_r   <= '0;
         r_rem <= is_rem;
         r_dz  <= w_dz;
         r_ov  <= w_ov;
         r_cnt <= '0;
`ifdef DIV_EARLY_OUT_EN
         if (w_early)
            r_result <= w_early_res;
`endif
      end else if (r_state == DIV_CALC && !w_fix) begin
         // trial sign bit clear means the divisor fit: keep the difference
         r_q   <= {r_q[DATA_LEN-2:0], ~w_sum[DATA_LEN]};
         r_r   <= w_sum[DATA_LEN] ? {r_r[DATA_LEN-2:0], r_q[DATA_LEN-1]} : w_sum[DATA_LEN-1:0];
         r_cnt <= r_cnt + CW'(1);
      end else if (r_state == DIV_CALC) begin
         r_result <= w_fix_res;
      end
   end
endmodule

// File: tb/tb_div_iter_ctrl.sv
// tb_div_iter_ctrl: scoreboard testbench for div_iter_ctrl.
module tb_div_iter_ctrl;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, is_signed, is_rem, out_ready;
   logic [31:0] op_a, op_b;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb_q[$];

`ifdef DIV_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 1;
`else
   localparam int SPECIAL_LAT = 34;
`endif
   localparam int NORMAL_LAT = 34;

   div_iter_ctrl #(.DATA_LEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .is_signed (is_signed),
      .is_rem    (is_rem),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r);
      logic [31:0] q, m;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         m = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         m = 32'd0;
      end else if (s) begin
         q = $signed(a) / $signed(b);
         m = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         m = a % b;
      end
      return r ? m : q;
   endfunction

   function automatic int lat_of(input logic [31:0] a, input logic [31:0] b, input logic s);
      return (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? SPECIAL_LAT : NORMAL_LAT;
   endfunction

   task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r);
      sb_q.push_back(model(a, b, s, r));
      op_a      = a;
      op_b      = b;
      is_signed = s;
      is_rem    = r;
      in_valid  = 1'b1;
      checks++;
      if (in_ready !== 1'b1)
         $display("FAIL start_in_ready: in_ready=%b required 1", in_ready);
      if (in_ready !== 1'b1)
         errors++;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic finish_op(input string name, input int exp_lat, input int hold);
      int lat = 1;
      logic [31:0] exp;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      exp = sb_q.size() > 0 ? sb_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, exp_lat);
      end
      checks++;
      if (result !== exp) begin
         errors++;
         $display("FAIL %s_result: got 0x%08h required 0x%08h", name, result, exp);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_in_ready_done: in_ready=%b required 0", name, in_ready);
      end
      repeat (hold) begin
         @(posedge clk);
         #1 checks++;
         if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: out_valid=%b result=0x%08h in_ready=%b required 1 0x%08h 0", name, out_valid, result, in_ready, exp);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_release: in_ready=%b out_valid=%b required 1 0", name, in_ready, out_valid);
      end
   endtask

   task automatic check_idle_outputs(input string name, input logic [31:0] exp_res);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
         errors++;
         $display("FAIL %s: in_ready=%b out_valid=%b busy=%b result=0x%08h required 1 0 0 0x%08h", name, in_ready, out_valid, busy, result, exp_res);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_idle_outputs("reset", 32'd0);
   endtask

   task automatic test_unsigned;
      start(32'd100, 32'd7, 1'b0, 1'b0);
      finish_op("udiv_100_7", NORMAL_LAT, 0);
      start(32'd100, 32'd7, 1'b0, 1'b1);
      finish_op("urem_100_7", NORMAL_LAT, 0);
   endtask

   task automatic test_signed;
      start(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      finish_op("div_m7_2", NORMAL_LAT, 0);
      start(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
      finish_op("rem_m7_2", NORMAL_LAT, 0);
      start(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
      finish_op("div_7_m2", NORMAL_LAT, 0);
      start(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
      finish_op("rem_7_m2", NORMAL_LAT, 0);
   endtask

   task automatic test_div_zero;
      start(32'd5, 32'd0, 1'b0, 1'b0);
      finish_op("divu_by0", SPECIAL_LAT, 0);
      start(32'd5, 32'd0, 1'b0, 1'b1);
      finish_op("remu_by0", SPECIAL_LAT, 0);
      start(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);
      finish_op("div_by0", SPECIAL_LAT, 0);
      start(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
      finish_op("rem_by0", SPECIAL_LAT, 0);
   endtask

   task automatic test_overflow;
      start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      finish_op("div_ovf", SPECIAL_LAT, 0);
      start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
      finish_op("rem_ovf", SPECIAL_LAT, 0);
      start(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      finish_op("divu_big", NORMAL_LAT, 0);
   endtask

   task automatic test_backpressure;
      start(32'd1000, 32'd7, 1'b0, 1'b0);
      finish_op("backpressure", NORMAL_LAT, 5);
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b;
      logic s, r;
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         s = 1'(i);
         r = 1'(i >> 1);
         start(a, b, s, r);
         finish_op("back_to_back", lat_of(a, b, s), 1);
      end
   endtask

   task automatic test_flush;
      bit seen = 1'b0;
      start(32'd1000, 32'd3, 1'b0, 1'b0);
      void'(sb_q.pop_back());
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: busy=%b in_ready=%b out_valid=%b required 0 1 0", busy, in_ready, out_valid);
      end
      repeat (40) begin
         @(posedge clk);
         #1 seen |= (out_valid === 1'b1);
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL flush_no_out: out_valid seen=1 required 0");
      end
      op_a     = 32'd9;
      op_b     = 32'd3;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_priority: busy=%b required 0", busy);
      end
      start(32'd9, 32'd3, 1'b0, 1'b0);
      finish_op("after_flush", NORMAL_LAT, 0);
   endtask

   task automatic test_reset_mid;
      start(32'd50, 32'd5, 1'b0, 1'b0);
      void'(sb_q.pop_back());
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check_idle_outputs("reset_mid", 32'd0);
      start(32'h1234_5678, 32'h0000_1234, 1'b0, 1'b1);
      finish_op("after_reset", NORMAL_LAT, 0);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
      is_signed = 1'b0;
      is_rem    = 1'b0;
      test_reset;
      test_unsigned;
      test_signed;
      test_div_zero;
      test_overflow;
      test_backpressure;
      test_back_to_back;
      test_flush;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
